tdp_bram_be_init: RTL

- Parametrised true dual-port block RAM, single clock. Successor to the fixed 32x16K dual-port RAM.
- Adds per-byte write enables, a selectable read-during-write mode, and an optional output register stage with a valid strobe.
- Adds same-address collision detection and a post-reset hardware clear of the whole array.
- Used as the generic on-chip buffer for packet and coefficient storage. Infers block RAM (ram_style block).

---
 rtl/tdp_bram_pkg.sv | 25 ++
 rtl/bram_clear_seq.sv | 72 +++++++
 rtl/tdp_bram_be_init.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/tdp_bram_pkg.sv
// Shared definitions for the byte-enabled true dual-port RAM with post-reset clear.
package tdp_bram_pkg;

    // Same-port read-during-write behaviour selectors
    localparam int RD_READ_FIRST  = 0;
    localparam int RD_WRITE_FIRST = 1;
    localparam int RD_NO_CHANGE   = 2;

    // Clear sequencer states
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // Number of byte lanes in a word
    function automatic int calc_nb(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    // True when the word splits evenly into byte lanes
    function automatic bit lanes_ok(input int data_w, input int byte_w);
        return ((data_w % byte_w) == 0) && (byte_w > 0);
    endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then parks in READY.
module bram_clear_seq
    import tdp_bram_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    clr_state_t        state_r;
    clr_state_t        state_next_s;
    logic [ADDR_W-1:0] cnt_r;

    // State register and clear address counter; reset restarts from address 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CLEAR;
            cnt_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == CLEAR) begin
                cnt_r <= cnt_r + ADDR_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next state: leave CLEAR once the last address has been written
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            READY:   state_next_s = READY;
            default: state_next_s = CLEAR;
        endcase
    end

    // Outputs decoded straight from the state and counter registers
    always_comb begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        clr_addr  = cnt_r;
        case (state_r)
            CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
            end
            READY: begin
                init_busy = 1'b0;
                clr_we    = 1'b0;
            end
            default: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/tdp_bram_be_init.sv
// Single-clock true dual-port block RAM with byte enables, selectable
// read-during-write mode, optional output register and post-reset clear.
module tdp_bram_be_init
    import tdp_bram_pkg::*;
#(
    parameter int               DATA_W   = 32,
    parameter int               ADDR_W   = 14,
    parameter int               BYTE_W   = 8,
    parameter int               RD_MODE  = 0,
    parameter int               OUT_REG  = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}},
    localparam int              NB       = calc_nb(DATA_W, BYTE_W)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    input  logic              en_a,
    input  logic [NB-1:0]     we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              dout_valid_a,
    input  logic              en_b,
    input  logic [NB-1:0]     we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              dout_valid_b,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (!lanes_ok(DATA_W, BYTE_W)) begin : g_bad_lanes
        $error("tdp_bram_be_init: DATA_W must be a multiple of BYTE_W");
    end
    if ((RD_MODE != RD_READ_FIRST) && (RD_MODE != RD_WRITE_FIRST) && (RD_MODE != RD_NO_CHANGE)) begin : g_bad_mode
        $error("tdp_bram_be_init: unsupported RD_MODE");
    end

    (* ram_style = "block" *) logic [DATA_W-1:0] mem_r [DEPTH];

    logic              init_busy_s;
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              take_a_s;
    logic              take_b_s;
    logic [NB-1:0]     wr_we_a_s;
    logic [ADDR_W-1:0] wr_addr_a_s;
    logic [DATA_W-1:0] wr_din_a_s;
    logic [DATA_W-1:0] rd_a_r;
    logic [DATA_W-1:0] rd_b_r;
    logic              vld_a_r;
    logic              vld_b_r;

    bram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy_s),
        .clr_we    (clr_we_s),
        .clr_addr  (clr_addr_s)
    );

    assign init_busy = init_busy_s;

    // Gate user accesses during the clear and steer the clear onto port A's write path
    always_comb begin
        take_a_s = en_a & ~init_busy_s;
        take_b_s = en_b & ~init_busy_s;
        if (clr_we_s) begin
            wr_we_a_s   = {NB{1'b1}};
            wr_addr_a_s = clr_addr_s;
            wr_din_a_s  = INIT_VAL;
        end else begin
            wr_we_a_s   = take_a_s ? we_a : {NB{1'b0}};
            wr_addr_a_s = addr_a;
            wr_din_a_s  = din_a;
        end
    end

    // Port A: byte-lane write plus stage-1 read register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_a_r  <= {DATA_W{1'b0}};
            vld_a_r <= 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_we_a_s[i]) begin
                    mem_r[wr_addr_a_s][i*BYTE_W +: BYTE_W] <= wr_din_a_s[i*BYTE_W +: BYTE_W];
                end
            end
            if (take_a_s) begin
                if ((|we_a) && (RD_MODE == RD_NO_CHANGE)) begin
                    rd_a_r  <= rd_a_r;
                    vld_a_r <= 1'b0;
                end else begin
                    for (int i = 0; i < NB; i++) begin
                        rd_a_r[i*BYTE_W +: BYTE_W] <= ((RD_MODE == RD_WRITE_FIRST) && we_a[i])
                            ? din_a[i*BYTE_W +: BYTE_W] : mem_r[addr_a][i*BYTE_W +: BYTE_W];
                    end
                    vld_a_r <= 1'b1;
                end
            end else begin
                rd_a_r  <= rd_a_r;
                vld_a_r <= 1'b0;
            end
        end
    end

    // Port B: byte-lane write plus stage-1 read register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_b_r  <= {DATA_W{1'b0}};
            vld_b_r <= 1'b0;
        end else begin
            if (take_b_s) begin
                for (int i = 0; i < NB; i++) begin
                    if (we_b[i]) begin
                        mem_r[addr_b][i*BYTE_W +: BYTE_W] <= din_b[i*BYTE_W +: BYTE_W];
                    end
                end
                if ((|we_b) && (RD_MODE == RD_NO_CHANGE)) begin
                    rd_b_r  <= rd_b_r;
                    vld_b_r <= 1'b0;
                end else begin
                    for (int i = 0; i < NB; i++) begin
                        rd_b_r[i*BYTE_W +: BYTE_W] <= ((RD_MODE == RD_WRITE_FIRST) && we_b[i])
                            ? din_b[i*BYTE_W +: BYTE_W] : mem_r[addr_b][i*BYTE_W +: BYTE_W];
                    end
                    vld_b_r <= 1'b1;
                end
            end else begin
                rd_b_r  <= rd_b_r;
                vld_b_r <= 1'b0;
            end
        end
    end

    // Same-address conflict involving at least one write, flagged one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            collision <= 1'b0;
        end else begin
            collision <= take_a_s & take_b_s & (addr_a == addr_b) & ((|we_a) | (|we_b));
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        // Output register: loads only with valid data so dout holds between reads
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_a       <= {DATA_W{1'b0}};
                dout_b       <= {DATA_W{1'b0}};
                dout_valid_a <= 1'b0;
                dout_valid_b <= 1'b0;
            end else begin
                dout_a       <= vld_a_r ? rd_a_r : dout_a;
                dout_b       <= vld_b_r ? rd_b_r : dout_b;
                dout_valid_a <= vld_a_r;
                dout_valid_b <= vld_b_r;
            end
        end
    end else begin : g_no_out_reg
        // Stage-1 registers drive the outputs directly
        always_comb begin
            dout_a       = rd_a_r;
            dout_b       = rd_b_r;
            dout_valid_a = vld_a_r;
            dout_valid_b = vld_b_r;
        end
    end

endmodule
